// File: rtl/mem_access.sv
// Memory stage of the pipelined RV32I core.
//
// mem_access_pkg holds the operation encoding and field widths that are
// shared with the other pipeline stages.
//
// mem_access takes the execute-stage bundle. Non-memory ops pass straight to
// writeback with one cycle of latency. A load or store runs over the
// byte-wide memory-controller port, one byte per handshake, least
// significant byte first. The upstream stage is stalled until the last byte
// is acknowledged.
//
// Ports:
//   clk, rst (async, active-low), rdy (global freeze when low)
//   in_valid/in_op/in_data/in_rd/in_addr : execute-stage bundle
//   mem_stall                            : upstream must hold its register
//   mc_req/mc_we/mc_addr/mc_wdata        : byte request to memory controller
//   mc_ack/mc_rdata                      : byte completion / read data
//   wb_valid/wb_rd/wb_data/wb_op         : writeback bundle (one-cycle pulse)

package mem_access_pkg;
    localparam int OP_LEN       = 5;
    localparam int REG_ADDR_LEN = 5;

    localparam logic [OP_LEN-1:0] OP_NOP  = 5'd0;
    localparam logic [OP_LEN-1:0] OP_ADD  = 5'd1;
    localparam logic [OP_LEN-1:0] OP_ADDI = 5'd2;
    localparam logic [OP_LEN-1:0] OP_SUB  = 5'd3;
    localparam logic [OP_LEN-1:0] OP_LB   = 5'd16;
    localparam logic [OP_LEN-1:0] OP_LH   = 5'd17;
    localparam logic [OP_LEN-1:0] OP_LW   = 5'd18;
    localparam logic [OP_LEN-1:0] OP_LBU  = 5'd19;
    localparam logic [OP_LEN-1:0] OP_LHU  = 5'd20;
    localparam logic [OP_LEN-1:0] OP_SB   = 5'd21;
    localparam logic [OP_LEN-1:0] OP_SH   = 5'd22;
    localparam logic [OP_LEN-1:0] OP_SW   = 5'd23;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    in_valid,
    input  logic [OP_LEN-1:0]       in_op,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [REG_ADDR_LEN-1:0] in_rd,
    input  logic [ADDR_W-1:0]       in_addr,
    output logic                    mem_stall,
    output logic                    mc_req,
    output logic                    mc_we,
    output logic [ADDR_W-1:0]       mc_addr,
    output logic [7:0]              mc_wdata,
    input  logic                    mc_ack,
    input  logic [7:0]              mc_rdata,
    output logic                    wb_valid,
    output logic [REG_ADDR_LEN-1:0] wb_rd,
    output logic [DATA_W-1:0]       wb_data,
    output logic [OP_LEN-1:0]       wb_op
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    function automatic logic is_store(input logic [OP_LEN-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem(input logic [OP_LEN-1:0] op);
        return is_store(op) || (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Index of the final byte of an access (byte count minus one).
    function automatic logic [IDX_W-1:0] last_idx(input logic [OP_LEN-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return IDX_W'(0);
            OP_LH, OP_LHU, OP_SH: return IDX_W'(1);
            default:              return IDX_W'(NB - 1);
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] data,
                                            input logic [IDX_W-1:0]  idx);
        logic [DATA_W-1:0] shifted;
        shifted = data >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [OP_LEN-1:0] op,
                                                   input logic [DATA_W-1:0] word);
        case (op)
            OP_LB:   return {{(DATA_W-8){word[7]}}, word[7:0]};
            OP_LH:   return {{(DATA_W-16){word[15]}}, word[15:0]};
            OP_LBU:  return {{(DATA_W-8){1'b0}}, word[7:0]};
            OP_LHU:  return {{(DATA_W-16){1'b0}}, word[15:0]};
            default: return word;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [OP_LEN-1:0]       op_q, op_d;
    logic [REG_ADDR_LEN-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [DATA_W-1:0]       asm_q, asm_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic                    mc_req_q, mc_req_d;
    logic                    mc_we_q, mc_we_d;
    logic [ADDR_W-1:0]       mc_addr_q, mc_addr_d;
    logic [7:0]              mc_wdata_q, mc_wdata_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [REG_ADDR_LEN-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]       wb_data_q, wb_data_d;
    logic [OP_LEN-1:0]       wb_op_q, wb_op_d;
    logic [DATA_W-1:0]       asm_s;
    logic                    mem_stall_s;

    // Next-state and next-output logic for the IDLE/ACCESS controller.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        op_d       = op_q;
        rd_d       = rd_q;
        data_d     = data_q;
        asm_d      = asm_q;
        base_d     = base_q;
        mc_req_d   = mc_req_q;
        mc_we_d    = mc_we_q;
        mc_addr_d  = mc_addr_q;
        mc_wdata_d = mc_wdata_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_op_d    = wb_op_q;
        asm_s      = asm_q;
        if (!rdy) begin
            // Frozen: even a pending writeback pulse is held.
            wb_valid_d = wb_valid_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && is_mem(in_op)) begin
                        op_d       = in_op;
                        rd_d       = in_rd;
                        data_d     = in_data;
                        base_d     = in_addr;
                        idx_d      = IDX_W'(0);
                        asm_d      = {DATA_W{1'b0}};
                        mc_req_d   = 1'b1;
                        mc_we_d    = is_store(in_op);
                        mc_addr_d  = in_addr;
                        mc_wdata_d = in_data[7:0];
                        state_d    = ST_ACCESS;
                    end else if (in_valid) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = in_rd;
                        wb_data_d  = in_data;
                        wb_op_d    = in_op;
                    end else begin
                        wb_valid_d = 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (mc_ack) begin
                        // Merge the returned byte so the final byte is usable
                        // for the writeback value in the same cycle.
                        for (int b = 0; b < NB; b++) begin
                            if (!is_store(op_q) && (idx_q == IDX_W'(b))) begin
                                asm_s[b*8 +: 8] = mc_rdata;
                            end else begin
                                asm_s[b*8 +: 8] = asm_q[b*8 +: 8];
                            end
                        end
                        asm_d = asm_s;
                        if (idx_q == last_idx(op_q)) begin
                            state_d    = ST_IDLE;
                            mc_req_d   = 1'b0;
                            mc_we_d    = 1'b0;
                            wb_valid_d = 1'b1;
                            wb_op_d    = op_q;
                            if (is_store(op_q)) begin
                                wb_rd_d   = {REG_ADDR_LEN{1'b0}};
                                wb_data_d = {DATA_W{1'b0}};
                            end else begin
                                wb_rd_d   = rd_q;
                                wb_data_d = load_ext(op_q, asm_s);
                            end
                        end else begin
                            idx_d      = idx_q + IDX_W'(1);
                            // Wraps modulo 2^ADDR_W; misaligned bases are fine.
                            mc_addr_d  = base_q + ADDR_W'(idx_q) + ADDR_W'(1);
                            mc_wdata_d = byte_sel(data_q, idx_q + IDX_W'(1));
                        end
                    end else begin
                        mc_req_d = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    mc_req_d = 1'b0;
                end
            endcase
        end
    end

    // Stall: a new memory op in IDLE, or any ACCESS cycle that does not
    // complete the final byte. Forced low while reset is asserted.
    always_comb begin
        mem_stall_s = 1'b0;
        if (!rst) begin
            mem_stall_s = 1'b0;
        end else if (state_q == ST_ACCESS) begin
            mem_stall_s = !(rdy && mc_ack && (idx_q == last_idx(op_q)));
        end else if (in_valid && is_mem(in_op)) begin
            mem_stall_s = 1'b1;
        end else begin
            mem_stall_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= IDX_W'(0);
            op_q       <= OP_NOP;
            rd_q       <= {REG_ADDR_LEN{1'b0}};
            data_q     <= {DATA_W{1'b0}};
            asm_q      <= {DATA_W{1'b0}};
            base_q     <= {ADDR_W{1'b0}};
            mc_req_q   <= 1'b0;
            mc_we_q    <= 1'b0;
            mc_addr_q  <= {ADDR_W{1'b0}};
            mc_wdata_q <= 8'h00;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= {REG_ADDR_LEN{1'b0}};
            wb_data_q  <= {DATA_W{1'b0}};
            wb_op_q    <= OP_NOP;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            asm_q      <= asm_d;
            base_q     <= base_d;
            mc_req_q   <= mc_req_d;
            mc_we_q    <= mc_we_d;
            mc_addr_q  <= mc_addr_d;
            mc_wdata_q <= mc_wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_op_q    <= wb_op_d;
        end
    end

    assign mem_stall = mem_stall_s;
    assign mc_req    = mc_req_q;
    assign mc_we     = mc_we_q;
    assign mc_addr   = mc_addr_q;
    assign mc_wdata  = mc_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_op     = wb_op_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed bundles push expected writeback
// and memory-controller transactions; a responder process plays the memory
// controller and a monitor process checks every writeback pulse.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, in_valid;
    logic [4:0]  in_op, in_rd;
    logic [31:0] in_data, in_addr;
    logic        mem_stall, mc_req, mc_we, mc_ack;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata, mc_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd, wb_op;
    logic [31:0] wb_data;

    typedef struct {logic we; logic [31:0] addr; logic [7:0] data;} mc_exp_t;
    typedef struct {logic [4:0] rd; logic [31:0] data; logic [4:0] op;} wb_exp_t;
    mc_exp_t mc_q[$];
    wb_exp_t wb_q[$];
    int checks   = 0;
    int failures = 0;
    int ack_wait = 0;

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_op(in_op),
        .in_data(in_data), .in_rd(in_rd), .in_addr(in_addr),
        .mem_stall(mem_stall), .mc_req(mc_req), .mc_we(mc_we),
        .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_ack(mc_ack),
        .mc_rdata(mc_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_op(wb_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic push_mc(input logic we, input logic [31:0] addr, input logic [7:0] data);
        mc_exp_t e;
        e.we = we; e.addr = addr; e.data = data;
        mc_q.push_back(e);
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data, input logic [4:0] op);
        wb_exp_t e;
        e.rd = rd; e.data = data; e.op = op;
        wb_q.push_back(e);
    endtask

    // Called at posedge+1 with the bundle already driven; returns after the
    // edge that accepts it, counting the stalled cycles.
    task automatic wait_accept(output int stalls);
        bit done;
        stalls = 0;
        done   = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout mem_stall stuck high, required low within 64 cycles");
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] data, input logic [4:0] rd,
                         input logic [31:0] addr, output int stalls);
        in_valid = 1'b1; in_op = op; in_data = data; in_rd = rd; in_addr = addr;
        wait_accept(stalls);
        in_valid = 1'b0; in_op = OP_NOP;
    endtask

    // Memory-controller model: acks after ack_wait cycles, checks each byte.
    initial begin : responder
        int wait_cnt;
        mc_exp_t e;
        wait_cnt = 0;
        mc_ack   = 1'b0;
        mc_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            mc_ack = 1'b0;
            if (!rst) begin
                wait_cnt = 0;
            end else if (rdy && mc_req) begin
                if (wait_cnt < ack_wait) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    mc_ack   = 1'b1;
                    if (mc_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mc_unexpected_req addr=0x%08h, required no request", mc_addr);
                    end else begin
                        e = mc_q.pop_front();
                        chk("mc_we", {31'd0, mc_we}, {31'd0, e.we});
                        chk("mc_addr", mc_addr, e.addr);
                        if (e.we) chk("mc_wdata", {24'd0, mc_wdata}, {24'd0, e.data});
                        else mc_rdata = e.data;
                    end
                end
            end
        end
    end

    // Writeback monitor.
    initial begin : monitor
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (rst && wb_valid) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected rd=%0d data=0x%08h, required no pulse", wb_rd, wb_data);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    chk("wb_data", wb_data, e.data);
                    chk("wb_op", {27'd0, wb_op}, {27'd0, e.op});
                end
            end
        end
    end

    initial begin : main
        int s;
        rst = 1'b0; rdy = 1'b1; in_valid = 1'b0; in_op = OP_NOP;
        in_data = 32'd0; in_rd = 5'd0; in_addr = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_mc_req", {31'd0, mc_req}, 32'd0);
        chk("rst_mc_we", {31'd0, mc_we}, 32'd0);
        chk("rst_mc_addr", mc_addr, 32'd0);
        chk("rst_mc_wdata", {24'd0, mc_wdata}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_op", {27'd0, wb_op}, {27'd0, OP_NOP});
        chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Pass-through ADD
        push_wb(5'd5, 32'h0000_1234, OP_ADD);
        issue(OP_ADD, 32'h0000_1234, 5'd5, 32'd0, s);
        chk("add_stalls", s, 32'd0);
        repeat (2) begin @(posedge clk); #1; end

        // LW with immediate acks
        ack_wait = 0;
        push_mc(1'b0, 32'h100, 8'h78); push_mc(1'b0, 32'h101, 8'h56);
        push_mc(1'b0, 32'h102, 8'h34); push_mc(1'b0, 32'h103, 8'h12);
        push_wb(5'd7, 32'h1234_5678, OP_LW);
        issue(OP_LW, 32'd0, 5'd7, 32'h100, s);
        chk("lw_stalls", s, 32'd4);

        // Sign/zero extension
        push_mc(1'b0, 32'h40, 8'h80);
        push_wb(5'd1, 32'hFFFF_FF80, OP_LB);
        issue(OP_LB, 32'd0, 5'd1, 32'h40, s);
        chk("lb_stalls", s, 32'd1);
        push_mc(1'b0, 32'h41, 8'h80);
        push_wb(5'd1, 32'h0000_0080, OP_LBU);
        issue(OP_LBU, 32'd0, 5'd1, 32'h41, s);
        push_mc(1'b0, 32'h10, 8'h01); push_mc(1'b0, 32'h11, 8'h90);
        push_wb(5'd8, 32'hFFFF_9001, OP_LH);
        issue(OP_LH, 32'd0, 5'd8, 32'h10, s);
        chk("lh_stalls", s, 32'd2);
        push_mc(1'b0, 32'h10, 8'h01); push_mc(1'b0, 32'h11, 8'h90);
        push_wb(5'd8, 32'h0000_9001, OP_LHU);
        issue(OP_LHU, 32'd0, 5'd8, 32'h10, s);

        // SH with two wait cycles per byte
        ack_wait = 2;
        push_mc(1'b1, 32'h200, 8'hDD); push_mc(1'b1, 32'h201, 8'hCC);
        push_wb(5'd0, 32'd0, OP_SH);
        issue(OP_SH, 32'hAABB_CCDD, 5'd9, 32'h200, s);
        chk("sh_stalls", s, 32'd6);

        // SW, immediate acks
        ack_wait = 0;
        push_mc(1'b1, 32'h204, 8'h11); push_mc(1'b1, 32'h205, 8'h22);
        push_mc(1'b1, 32'h206, 8'h33); push_mc(1'b1, 32'h207, 8'h44);
        push_wb(5'd0, 32'd0, OP_SW);
        issue(OP_SW, 32'h4433_2211, 5'd12, 32'h204, s);

        // Address wrap
        push_mc(1'b0, 32'hFFFF_FFFF, 8'h34); push_mc(1'b0, 32'h0000_0000, 8'h12);
        push_wb(5'd3, 32'h0000_1234, OP_LH);
        issue(OP_LH, 32'd0, 5'd3, 32'hFFFF_FFFF, s);
        chk("wrap_stalls", s, 32'd2);

        // Load to x0 still pulses
        push_mc(1'b0, 32'h20, 8'hEF); push_mc(1'b0, 32'h21, 8'hBE);
        push_mc(1'b0, 32'h22, 8'hAD); push_mc(1'b0, 32'h23, 8'hDE);
        push_wb(5'd0, 32'hDEAD_BEEF, OP_LW);
        issue(OP_LW, 32'd0, 5'd0, 32'h20, s);

        // Freeze during an LW wait
        ack_wait = 3;
        push_mc(1'b0, 32'h300, 8'h0D); push_mc(1'b0, 32'h301, 8'hF0);
        push_mc(1'b0, 32'h302, 8'hFE); push_mc(1'b0, 32'h303, 8'hCA);
        push_wb(5'd2, 32'hCAFE_F00D, OP_LW);
        in_valid = 1'b1; in_op = OP_LW; in_data = 32'd0; in_rd = 5'd2; in_addr = 32'h300;
        @(posedge clk); #1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_mc_req", {31'd0, mc_req}, 32'd1);
            chk("frz_mc_addr", mc_addr, 32'h300);
            chk("frz_mem_stall", {31'd0, mem_stall}, 32'd1);
            chk("frz_wb_valid", {31'd0, wb_valid}, 32'd0);
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        wait_accept(s);
        in_valid = 1'b0; in_op = OP_NOP;

        // Reset after the first byte of an LW
        ack_wait = 2;
        push_mc(1'b0, 32'h400, 8'h5A);
        in_valid = 1'b1; in_op = OP_LW; in_rd = 5'd4; in_addr = 32'h400;
        repeat (4) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        chk("arst_mc_req", {31'd0, mc_req}, 32'd0);
        chk("arst_mc_addr", mc_addr, 32'd0);
        chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("arst_mem_stall", {31'd0, mem_stall}, 32'd0);
        chk("arst_mc_q_drained", mc_q.size(), 32'd0);
        in_valid = 1'b0; in_op = OP_NOP;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        push_wb(5'd6, 32'h0000_0042, OP_ADDI);
        issue(OP_ADDI, 32'h0000_0042, 5'd6, 32'd0, s);
        chk("addi_stalls", s, 32'd0);

        // Idle: wb fields hold, no pulse
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("idle_wb_rd", {27'd0, wb_rd}, 32'd6);
        chk("idle_wb_data", wb_data, 32'h0000_0042);
        chk("idle_wb_op", {27'd0, wb_op}, {27'd0, OP_ADDI});

        repeat (3) @(posedge clk);
        chk("wb_q_empty", wb_q.size(), 32'd0);
        chk("mc_q_empty", mc_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
